mesi_isc_breq_arb: RTL and testbench

//  Round-robin arbiter between the 4 CPU main-bus ports for broadcast requests
//  (WR_BROAD/RD_BROAD). Picks one requester, writes a broadcast entry (type,
//  cpu id, address, broadcast id) into the broadcast FIFO and acks the winner.

---
 rtl/mesi_isc_breq_arb_if.sv | 30 +++
 rtl/mesi_isc_breq_arb.sv | 119 +++++++++++
 tb/tb_mesi_isc_breq_arb.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mesi_isc_breq_arb_if.sv
// Main-bus request side and broadcast-FIFO write side of the broadcast request arbiter.
// The master modport drives the CPU commands/addresses and the FIFO full flag.
interface mesi_isc_breq_arb_if #(
    parameter int MBUS_CMD_WIDTH   = 3,
    parameter int ADDR_WIDTH       = 32,
    parameter int BROAD_TYPE_WIDTH = 2,
    parameter int BROAD_ID_WIDTH   = 5
);
    logic [4*MBUS_CMD_WIDTH-1:0] mbus_cmd_array_i;
    logic [4*ADDR_WIDTH-1:0]     mbus_addr_array_i;
    logic                        fifo_status_full_i;
    logic [3:0]                  mbus_ack_array_o;
    logic                        broad_fifo_wr_o;
    logic [ADDR_WIDTH-1:0]       broad_addr_o;
    logic [BROAD_TYPE_WIDTH-1:0] broad_type_o;
    logic [1:0]                  broad_cpu_id_o;
    logic [BROAD_ID_WIDTH-1:0]   broad_id_o;

    modport master (
        output mbus_cmd_array_i, mbus_addr_array_i, fifo_status_full_i,
        input  mbus_ack_array_o, broad_fifo_wr_o, broad_addr_o, broad_type_o,
               broad_cpu_id_o, broad_id_o
    );

    modport slave (
        input  mbus_cmd_array_i, mbus_addr_array_i, fifo_status_full_i,
        output mbus_ack_array_o, broad_fifo_wr_o, broad_addr_o, broad_type_o,
               broad_cpu_id_o, broad_id_o
    );
endinterface

// File: rtl/mesi_isc_breq_arb.sv
// Round-robin arbiter for WR_BROAD/RD_BROAD requests from 4 CPUs; writes one
// broadcast entry into the broadcast FIFO and acks the winner, at most every 2 cycles.
module mesi_isc_breq_arb #(
    parameter int MBUS_CMD_WIDTH   = 3,
    parameter int ADDR_WIDTH       = 32,
    parameter int BROAD_TYPE_WIDTH = 2,
    parameter int BROAD_ID_WIDTH   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    mesi_isc_breq_arb_if.slave   bus
);
    typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_e;

    localparam logic [MBUS_CMD_WIDTH-1:0]   CMD_WR_BROAD = MBUS_CMD_WIDTH'(3);
    localparam logic [MBUS_CMD_WIDTH-1:0]   CMD_RD_BROAD = MBUS_CMD_WIDTH'(4);
    localparam logic [BROAD_TYPE_WIDTH-1:0] TYPE_WR      = BROAD_TYPE_WIDTH'(1);
    localparam logic [BROAD_TYPE_WIDTH-1:0] TYPE_RD      = BROAD_TYPE_WIDTH'(2);

    state_e                      state_q, state_d;
    logic [1:0]                  rr_ptr_q, rr_ptr_d;
    logic [BROAD_ID_WIDTH-1:0]   id_cnt_q, id_cnt_d;
    logic [3:0]                  ack_q, ack_d;
    logic                        wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
    logic [BROAD_TYPE_WIDTH-1:0] type_q, type_d;
    logic [1:0]                  cpu_id_q, cpu_id_d;
    logic [BROAD_ID_WIDTH-1:0]   id_q, id_d;

    logic [MBUS_CMD_WIDTH-1:0]   cmd [4];
    logic [ADDR_WIDTH-1:0]       addr [4];
    logic [3:0]                  req;
    logic                        found;
    logic [1:0]                  winner;
    logic [1:0]                  idx;

    // Request decode and round-robin pick: scan from the CPU after the last winner.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        found  = 1'b0;
        winner = rr_ptr_q;
        idx    = rr_ptr_q;
        for (int i = 0; i < 4; i++) begin
            cmd[i]  = bus.mbus_cmd_array_i[i*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH];
            addr[i] = bus.mbus_addr_array_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            req[i]  = (cmd[i] == CMD_WR_BROAD) || (cmd[i] == CMD_RD_BROAD);
        end
        for (int k = 1; k <= 4; k++) begin
            idx = rr_ptr_q + 2'(k);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_cnt_d = id_cnt_q;
        ack_d    = 4'b0000;
        wr_d     = 1'b0;
        addr_d   = addr_q;
        type_d   = type_q;
        cpu_id_d = cpu_id_q;
        id_d     = id_q;
        case (state_q)
            IDLE: begin
                if (found && !bus.fifo_status_full_i) begin
                    state_d         = ACK;
                    ack_d[winner]   = 1'b1;
                    wr_d            = 1'b1;
                    addr_d          = addr[winner];
                    type_d          = (cmd[winner] == CMD_WR_BROAD) ? TYPE_WR : TYPE_RD;
                    cpu_id_d        = winner;
                    id_d            = id_cnt_q;
                    rr_ptr_d        = winner;
                    id_cnt_d        = id_cnt_q + 1'b1;
                end
            end
            // Full is ignored here: the in-flight write always completes.
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // rr_ptr resets to 3 so CPU0 has highest priority after reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= 2'd3;
            id_cnt_q <= '0;
            ack_q    <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            type_q   <= '0;
            cpu_id_q <= '0;
            id_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_cnt_q <= id_cnt_d;
            ack_q    <= ack_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            type_q   <= type_d;
            cpu_id_q <= cpu_id_d;
            id_q     <= id_d;
        end
    end

    assign bus.mbus_ack_array_o = ack_q;
    assign bus.broad_fifo_wr_o  = wr_q;
    assign bus.broad_addr_o     = addr_q;
    assign bus.broad_type_o     = type_q;
    assign bus.broad_cpu_id_o   = cpu_id_q;
    assign bus.broad_id_o       = id_q;
endmodule

// File: tb/tb_mesi_isc_breq_arb.sv
// Directed bench for mesi_isc_breq_arb: reset, round robin, FIFO full, non-request
// commands, broadcast id wrap, and output invariants under random stimulus.
module tb_mesi_isc_breq_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    mesi_isc_breq_arb_if bus ();

    mesi_isc_breq_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int cpu, input logic [2:0] c);
        bus.mbus_cmd_array_i[cpu*3 +: 3] = c;
    endtask

    function automatic logic [31:0] cpu_addr(input int cpu);
        return 32'hA000_0000 + 32'(cpu) * 32'h0000_1111;
    endfunction

    task automatic do_reset();
        bus.mbus_cmd_array_i   = '0;
        bus.fifo_status_full_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_wr"},  32'(bus.broad_fifo_wr_o),  32'd0);
        check({tag, "_ack"}, 32'(bus.mbus_ack_array_o), 32'd0);
    endtask

    logic prev_wr;
    logic [3:0] exp_ack;

    initial begin
        bus.mbus_cmd_array_i   = '0;
        bus.fifo_status_full_i = 1'b0;
        for (int i = 0; i < 4; i++) bus.mbus_addr_array_i[i*32 +: 32] = cpu_addr(i);

        // Reset state
        tick();
        check_idle("rst");
        check("rst_addr",  bus.broad_addr_o, 32'd0);
        check("rst_type",  32'(bus.broad_type_o), 32'd0);
        check("rst_cpuid", 32'(bus.broad_cpu_id_o), 32'd0);
        check("rst_id",    32'(bus.broad_id_o), 32'd0);
        rst = 1'b0;

        // 1. Reset asserted mid-ACK clears outputs immediately
        set_cmd(2, 3'd4);
        tick();
        check("pre_ack", 32'(bus.mbus_ack_array_o), 32'h4);
        rst = 1'b1;
        #2;
        check_idle("midack_rst");
        check("midack_addr", bus.broad_addr_o, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("t1_ack",   32'(bus.mbus_ack_array_o), 32'h4);
        check("t1_wr",    32'(bus.broad_fifo_wr_o), 32'd1);
        check("t1_type",  32'(bus.broad_type_o), 32'd2);
        check("t1_cpuid", 32'(bus.broad_cpu_id_o), 32'd2);
        check("t1_id",    32'(bus.broad_id_o), 32'd0);
        check("t1_addr",  bus.broad_addr_o, cpu_addr(2));
        set_cmd(2, 3'd0);
        tick();
        check_idle("t1_after");

        // 2. All CPUs WR_BROAD: grants rotate 0,1,2,3,0
        do_reset();
        for (int i = 0; i < 4; i++) set_cmd(i, 3'd3);
        for (int g = 0; g < 5; g++) begin
            tick();
            exp_ack = 4'b0001 << (g % 4);
            check("rr_ack",   32'(bus.mbus_ack_array_o), 32'(exp_ack));
            check("rr_id",    32'(bus.broad_id_o), 32'(g));
            check("rr_type",  32'(bus.broad_type_o), 32'd1);
            check("rr_addr",  bus.broad_addr_o, cpu_addr(g % 4));
            set_cmd(g % 4, 3'd0);
            tick();
            check_idle("rr_gap");
            set_cmd(g % 4, 3'd3);
        end

        // 3. FIFO full blocks grants until it drops
        do_reset();
        bus.fifo_status_full_i = 1'b1;
        set_cmd(1, 3'd4);
        for (int c = 0; c < 10; c++) begin
            tick();
            check_idle("full_block");
        end
        bus.fifo_status_full_i = 1'b0;
        tick();
        check("full_rel_ack", 32'(bus.mbus_ack_array_o), 32'h2);
        check("full_rel_wr",  32'(bus.broad_fifo_wr_o), 32'd1);
        bus.fifo_status_full_i = 1'b1;
        set_cmd(1, 3'd0);
        tick();
        check_idle("full_in_ack");
        bus.fifo_status_full_i = 1'b0;

        // 4. Non-broadcast and illegal commands are not requests
        do_reset();
        set_cmd(3, 3'd1);
        set_cmd(0, 3'd2);
        set_cmd(1, 3'd6);
        for (int c = 0; c < 5; c++) begin
            tick();
            check_idle("nonreq");
        end
        set_cmd(1, 3'd3);
        tick();
        check("nonreq_ack",  32'(bus.mbus_ack_array_o), 32'h2);
        check("nonreq_type", 32'(bus.broad_type_o), 32'd1);
        bus.mbus_cmd_array_i = '0;
        tick();

        // 5. Broadcast id wraps after 32 entries
        do_reset();
        set_cmd(2, 3'd4);
        for (int g = 0; g < 33; g++) begin
            tick();
            check("wrap_wr", 32'(bus.broad_fifo_wr_o), 32'd1);
            check("wrap_id", 32'(bus.broad_id_o), 32'(g % 32));
            tick();
            check("wrap_gap", 32'(bus.broad_fifo_wr_o), 32'd0);
            check("wrap_hold", 32'(bus.broad_id_o), 32'(g % 32));
        end
        set_cmd(2, 3'd0);

        // 6. Invariants under random stimulus
        do_reset();
        prev_wr = 1'b0;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 4; i++) set_cmd(i, 3'($urandom_range(0, 7)));
            bus.fifo_status_full_i = ($urandom_range(0, 3) == 0);
            tick();
            check("inv_onehot", 32'($onehot0(bus.mbus_ack_array_o)), 32'd1);
            check("inv_wr_ack", 32'(bus.broad_fifo_wr_o), 32'(|bus.mbus_ack_array_o));
            check("inv_no_b2b", 32'(prev_wr && bus.broad_fifo_wr_o), 32'd0);
            prev_wr = bus.broad_fifo_wr_o;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
